// File: rtl/addsub_pkg.sv
// Shared encodings for the multi-precision add/subtract sequencer:
// operation codes and sequencer FSM states.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/addsub.sv
// One-word add/subtract slice. Operands arrive zero-extended by one bit so the
// raw carry (add) or raw borrow (sub) appears in the top bit of the result.
module addsub
  import addsub_pkg::*;
#(
  parameter int DBW = 8
) (
  input  logic           op,
  input  logic           ci,
  input  logic [DBW:0]   a,
  input  logic [DBW:0]   b,
  output logic [DBW-1:0] s,
  output logic           co,
  output logic           v
);

  logic [DBW:0] cin_s;
  logic [DBW:0] full_s;

  // Carry-in is 6502 style on subtract: ci=1 means no borrow, so it is inverted into the borrow term.
  always_comb begin
    cin_s  = {{DBW{1'b0}}, 1'b0};
    full_s = {(DBW+1){1'b0}};
    if (op == OP_SUB) begin
      cin_s  = {{DBW{1'b0}}, ~ci};
      full_s = a - b - cin_s;
    end else begin
      cin_s  = {{DBW{1'b0}}, ci};
      full_s = a + b + cin_s;
    end
  end

  assign s  = full_s[DBW-1:0];
  assign co = full_s[DBW];

  // Signed overflow of this word, taking the carry/borrow-in into account.
  always_comb begin
    v = 1'b0;
    if (op == OP_SUB) begin
      v = (a[DBW-1] != b[DBW-1]) && (full_s[DBW-1] != a[DBW-1]);
    end else begin
      v = (a[DBW-1] == b[DBW-1]) && (full_s[DBW-1] != a[DBW-1]);
    end
  end

endmodule

// File: rtl/addsub_mp_seq.sv
// Multi-precision add/subtract sequencer: round-robin arbitration between two
// requesters, each operation run word-serially LSW first through one addsub.
module addsub_mp_seq
  import addsub_pkg::*;
#(
  parameter int DBW   = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic                   op0,
  input  logic                   op1,
  input  logic                   ci0,
  input  logic                   ci1,
  input  logic [DBW*WORDS-1:0]   a0,
  input  logic [DBW*WORDS-1:0]   a1,
  input  logic [DBW*WORDS-1:0]   b0,
  input  logic [DBW*WORDS-1:0]   b1,
  output logic [1:0]             ack,
  output logic                   busy,
  output logic                   done,
  output logic                   done_id,
  output logic [DBW*WORDS-1:0]   o,
  output logic                   co,
  output logic                   v,
  output logic                   z
);

  localparam int W    = DBW * WORDS;
  localparam int IDXW = $clog2(WORDS);

  state_t            state_r, state_s;
  logic              grant_s, win_s, last_word_s;
  logic              last_r, id_r, op_r, c_r;
  logic [IDXW-1:0]   idx_r;
  logic [W-1:0]      a_sh_r, b_sh_r, res_sh_r, res_next_s;
  logic [1:0]        ack_r;
  logic              done_r, done_id_r, co_r, v_r, z_r;
  logic [W-1:0]      o_r;
  logic [DBW-1:0]    sum_s;
  logic              co_raw_s, v_raw_s, c_next_s;

  addsub #(.DBW(DBW)) u_addsub (
    .op (op_r),
    .ci (c_r),
    .a  ({1'b0, a_sh_r[DBW-1:0]}),
    .b  ({1'b0, b_sh_r[DBW-1:0]}),
    .s  (sum_s),
    .co (co_raw_s),
    .v  (v_raw_s)
  );

  // Round-robin arbiter: on a tie the requester not served last wins.
  always_comb begin
    grant_s = 1'b0;
    win_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      case (req)
        2'b01:   begin grant_s = 1'b1; win_s = 1'b0;    end
        2'b10:   begin grant_s = 1'b1; win_s = 1'b1;    end
        2'b11:   begin grant_s = 1'b1; win_s = ~last_r; end
        default: begin grant_s = 1'b0; win_s = 1'b0;    end
      endcase
    end else begin
      grant_s = 1'b0;
      win_s   = 1'b0;
    end
  end

  assign last_word_s = (idx_r == IDXW'(WORDS - 1));
  assign c_next_s    = (op_r == OP_SUB) ? ~co_raw_s : co_raw_s;
  assign res_next_s  = {sum_s, res_sh_r[W-1:DBW]};

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) state_s = ST_RUN;
        else         state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_word_s) state_s = ST_DONE;
        else             state_s = ST_RUN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Operand capture, word-serial shifting, carry chaining and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r    <= 1'b1;
      id_r      <= 1'b0;
      op_r      <= OP_ADD;
      c_r       <= 1'b0;
      idx_r     <= {IDXW{1'b0}};
      a_sh_r    <= {W{1'b0}};
      b_sh_r    <= {W{1'b0}};
      res_sh_r  <= {W{1'b0}};
      ack_r     <= 2'b00;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
      o_r       <= {W{1'b0}};
      co_r      <= 1'b0;
      v_r       <= 1'b0;
      z_r       <= 1'b0;
    end else begin
      ack_r  <= 2'b00;
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            op_r   <= win_s ? op1 : op0;
            c_r    <= win_s ? ci1 : ci0;
            a_sh_r <= win_s ? a1 : a0;
            b_sh_r <= win_s ? b1 : b0;
            idx_r  <= {IDXW{1'b0}};
            id_r   <= win_s;
            last_r <= win_s;
            ack_r  <= win_s ? 2'b10 : 2'b01;
          end
        end
        ST_RUN: begin
          a_sh_r   <= a_sh_r >> DBW;
          b_sh_r   <= b_sh_r >> DBW;
          res_sh_r <= res_next_s;
          c_r      <= c_next_s;
          idx_r    <= idx_r + IDXW'(1);
          // Final word: publish the complete result together with the done pulse.
          if (last_word_s) begin
            o_r       <= res_next_s;
            co_r      <= c_next_s;
            v_r       <= v_raw_s;
            z_r       <= (res_next_s == {W{1'b0}});
            done_r    <= 1'b1;
            done_id_r <= id_r;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state_r != ST_IDLE);
  assign ack     = ack_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign o       = o_r;
  assign co      = co_r;
  assign v       = v_r;
  assign z       = z_r;

endmodule

// File: tb/tb_addsub_mp_seq.sv
// Directed bench for addsub_mp_seq (DBW=8, WORDS=4) with a full-width reference
// model feeding a scoreboard that is checked on every done pulse.
module tb_addsub_mp_seq;
  import addsub_pkg::*;

  localparam int DBW   = 8;
  localparam int WORDS = 4;
  localparam int W     = DBW * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic         op0 = 1'b0, op1 = 1'b0, ci0 = 1'b0, ci1 = 1'b0;
  logic [W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [1:0]   ack;
  logic         busy, done, done_id, co, v, z;
  logic [W-1:0] o;

  addsub_mp_seq #(.DBW(DBW), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .op0(op0), .op1(op1), .ci0(ci0), .ci1(ci1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack(ack), .busy(busy), .done(done), .done_id(done_id),
    .o(o), .co(co), .v(v), .z(z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [W-1:0] o;
    logic         co;
    logic         v;
    logic         z;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned done_cycs[$];
  int unsigned cyc = 0;
  int          ack_cnt0 = 0, ack_cnt1 = 0;
  int          checks = 0, errors = 0;
  logic [W+3:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic id, input logic op, input logic ci,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int unsigned c);
    exp_t e;
    logic [W:0] f;
    if (op == OP_SUB) f = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ~ci};
    else              f = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.id  = id;
    e.o   = f[W-1:0];
    e.co  = (op == OP_SUB) ? ~f[W] : f[W];
    e.v   = (op == OP_SUB) ? ((a[W-1] != b[W-1]) && (e.o[W-1] != a[W-1]))
                           : ((a[W-1] == b[W-1]) && (e.o[W-1] != a[W-1]));
    e.z   = (e.o == '0);
    e.cyc = c;
    return e;
  endfunction

  // Scoreboard: compare each done against the oldest expectation; outputs must hold between dones.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
    end else begin
      if (ack[0]) ack_cnt0++;
      if (ack[1]) ack_cnt1++;
      if (done) begin
        done_cycs.push_back(cyc);
        chk("done_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("done_id", 64'(done_id), 64'(e.id));
          chk("o",       64'(o),       64'(e.o));
          chk("co",      64'(co),      64'(e.co));
          chk("v",       64'(v),       64'(e.v));
          chk("z",       64'(z),       64'(e.z));
          chk("latency", 64'(cyc - e.cyc), 64'(WORDS));
        end
        held = {done_id, o, co, v, z};
      end else begin
        chk("outputs_held", 64'({done_id, o, co, v, z}), 64'(held));
      end
    end
  end

  task automatic set_ops(input logic id, input logic op, input logic ci,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin op1 = op; ci1 = ci; a1 = a; b1 = b; end
    else    begin op0 = op; ci0 = ci; a0 = a; b0 = b; end
  endtask

  task automatic push_exp(input logic id);
    if (id) sb.push_back(model(1'b1, op1, ci1, a1, b1, cyc));
    else    sb.push_back(model(1'b0, op0, ci0, a0, b0, cyc));
  endtask

  // Raise req[id], wait (bounded) for its ack, record the expectation, drop req.
  task automatic issue(input logic id, input logic op, input logic ci,
                       input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    set_ops(id, op, ci, a, b);
    req[id] = 1'b1;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (ack[id]) begin seen = 1'b1; lat = n; end
    end
    chk("ack_seen", 64'(seen), 64'(1));
    if (seen) push_exp(id);
    req[id] = 1'b0;
  endtask

  task automatic wait_idle;
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 20 && !idle; n++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    chk("idle_reached", 64'(idle), 64'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, a_base0, a_base1;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({ack, busy, done, done_id, o, co, v, z}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_outputs", 64'({ack, busy, done, done_id, o, co, v, z}), 64'(0));

    // Test 1: add with carry across a word boundary, ack latency 1
    issue(1'b0, OP_ADD, 1'b0, 32'h0000_00FF, 32'h0000_0001, lat);
    chk("ack_latency", 64'(lat), 64'(1));
    wait_idle();
    chk("t1_o", 64'(o), 64'(32'h0000_0100));

    // Test 2: subtract with borrow out
    issue(1'b1, OP_SUB, 1'b1, 32'h0000_0000, 32'h0000_0001, lat);
    wait_idle();
    chk("t2_o_co", 64'({o, co}), 64'({32'hFFFF_FFFF, 1'b0}));

    // Test 3: signed overflow and zero result
    issue(1'b0, OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    wait_idle();
    chk("t3_v", 64'({o, v, co}), 64'({32'h8000_0000, 1'b1, 1'b0}));
    issue(1'b0, OP_SUB, 1'b1, 32'h1234_5678, 32'h1234_5678, lat);
    wait_idle();
    chk("t3_z", 64'({o, z, co}), 64'({32'h0, 1'b1, 1'b1}));
    issue(1'b1, OP_SUB, 1'b0, 32'h8000_0000, 32'h0000_0000, lat);
    wait_idle();

    // Test 4: both requests held from reset; grants alternate 0,1,0,1
    @(negedge clk); #2;
    rst_n = 1'b0;
    req = 2'b11;
    set_ops(1'b0, OP_ADD, 1'b0, 32'h1111_1111, 32'h2222_2222);
    set_ops(1'b1, OP_SUB, 1'b1, 32'h0000_1000, 32'h0000_2000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s0 = done_cycs.size();
    a_base0 = ack_cnt0;
    a_base1 = ack_cnt1;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (ack != 2'b00) seen = 1'b1;
      end
      chk("rr_ack_seen", 64'(seen), 64'(1));
      chk("rr_order", 64'(ack), 64'((k % 2) ? 2'b10 : 2'b01));
      if (seen) begin
        push_exp(ack[1]);
        set_ops(ack[1], k[0], $urandom_range(1, 0), W'($urandom), W'($urandom));
      end
    end
    req = 2'b00;
    wait_idle();
    chk("rr_done_count", 64'(done_cycs.size() - s0), 64'(4));
    for (int i = 0; i < 3; i++)
      if (done_cycs.size() >= s0 + 4)
        chk("rr_done_spacing", 64'(done_cycs[s0+i+1] - done_cycs[s0+i]), 64'(WORDS + 2));
    chk("rr_ack_count", 64'((ack_cnt0 - a_base0) * 16 + (ack_cnt1 - a_base1)), 64'(2 * 16 + 2));

    // Test 5: reset in the middle of RUN aborts at once with no done
    issue(1'b0, OP_ADD, 1'b0, 32'h0000_0005, 32'h0000_0006, lat);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'({ack, busy, done, done_id, o, co, v, z}), 64'(0));
    sb.delete();
    s0 = done_cycs.size();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 64'(done_cycs.size()), 64'(s0));
    issue(1'b1, OP_ADD, 1'b0, 32'h0000_0001, 32'h0000_0001, lat);
    wait_idle();
    chk("after_abort", 64'({o, done_id}), 64'({32'h0000_0002, 1'b1}));

    // Test 6: requester 0 withdraws before grant; only requester 1 is served
    issue(1'b1, OP_ADD, 1'b1, 32'h0000_0010, 32'h0000_0020, lat);
    @(negedge clk);
    set_ops(1'b0, OP_ADD, 1'b0, 32'hDEAD_BEEF, 32'h1);
    set_ops(1'b1, OP_SUB, 1'b1, 32'h0000_0100, 32'h0000_0001);
    req = 2'b11;
    repeat (2) @(negedge clk);
    req[0] = 1'b0;
    a_base0 = ack_cnt0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (ack != 2'b00) seen = 1'b1;
    end
    chk("withdraw_ack", 64'(ack), 64'(2'b10));
    if (seen) push_exp(1'b1);
    req = 2'b00;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("withdraw_no_ack0", 64'(ack_cnt0 - a_base0), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
